// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared grid constants, direction/status encodings and a bounds helper for
// the 10x10 maze planner/navigator pair.
// ---------------------------------------------------------------------------
package maze_pkg;

    localparam int unsigned GRID_W   = 10;
    localparam int unsigned GRID_H   = 10;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned DIST_W   = 7;
    localparam logic [DIST_W-1:0] DIST_INF = 7'h7F;

    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_E = 2'b01,
        DIR_S = 2'b10,
        DIR_W = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_REACHED = 2'b01,
        ST_BLOCKED = 2'b10,
        ST_LIMIT   = 2'b11
    } nav_status_t;

    // True when one step from (x,y) in direction dir stays on the grid.
    function automatic logic step_in_bounds(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y,
                                            input dir_t               dir);
        logic ok;
        ok = 1'b0;
        case (dir)
            DIR_N:   ok = (y != COORD_W'(0));
            DIR_E:   ok = (x != COORD_W'(GRID_W - 1));
            DIR_S:   ok = (y != COORD_W'(GRID_H - 1));
            DIR_W:   ok = (x != COORD_W'(0));
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/maze_nav_controller.sv
// ---------------------------------------------------------------------------
// maze_nav_controller
// Closed-loop navigator: holds the robot cell, requests a BFS plan for it,
// turns the planner's answer into one move over a valid/ready handshake and
// advances until goal reached, blocked, step limit or abort.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   run, abort                start pulse / abort level
//   start_x/y, goal_x/y       run coordinates (latched on run)
//   bfs_start                 one-cycle plan request
//   bfs_curr_x/y, bfs_goal_x/y position and goal presented to the planner
//   bfs_done/dist/dir/valid   planner result
//   move_valid/dir, move_ready move handshake to the motion stage
//   pos_x/y, step_count       current position and moves completed
//   busy, finished, status    run state, end-of-run pulse, outcome
// ---------------------------------------------------------------------------
module maze_nav_controller
    import maze_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                abort,
    input  logic [COORD_W-1:0]  start_x,
    input  logic [COORD_W-1:0]  start_y,
    input  logic [COORD_W-1:0]  goal_x,
    input  logic [COORD_W-1:0]  goal_y,
    output logic                bfs_start,
    output logic [COORD_W-1:0]  bfs_curr_x,
    output logic [COORD_W-1:0]  bfs_curr_y,
    output logic [COORD_W-1:0]  bfs_goal_x,
    output logic [COORD_W-1:0]  bfs_goal_y,
    input  logic                bfs_done,
    input  logic [DIST_W-1:0]   bfs_dist,
    input  logic [1:0]          bfs_dir,
    input  logic                bfs_valid,
    output logic                move_valid,
    output logic [1:0]          move_dir,
    input  logic                move_ready,
    output logic [COORD_W-1:0]  pos_x,
    output logic [COORD_W-1:0]  pos_y,
    output logic [DIST_W-1:0]   step_count,
    output logic                busy,
    output logic                finished,
    output logic [1:0]          status
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_EVAL  = 3'd4,
        S_ISSUE = 3'd5,
        S_FIN   = 3'd6
    } nav_state_t;

    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(GRID_H - 1);
    localparam logic [DIST_W-1:0]  STEP_LIMIT = DIST_W'(MAX_STEPS);

    nav_state_t          state_q;
    logic [COORD_W-1:0]  pos_x_q, pos_y_q, goal_x_q, goal_y_q;
    logic [DIST_W-1:0]   step_q;
    logic [DIST_W-1:0]   dist_q;
    dir_t                plan_dir_q;
    logic                plan_valid_q;
    dir_t                move_dir_q;
    logic                move_valid_q, bfs_start_q, finished_q, busy_q;
    nav_status_t         status_q;

    // Navigation FSM with registered outputs and position/step counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            goal_x_q     <= '0;
            goal_y_q     <= '0;
            step_q       <= '0;
            dist_q       <= '0;
            plan_dir_q   <= DIR_N;
            plan_valid_q <= 1'b0;
            move_dir_q   <= DIR_N;
            move_valid_q <= 1'b0;
            bfs_start_q  <= 1'b0;
            finished_q   <= 1'b0;
            busy_q       <= 1'b0;
            status_q     <= ST_NONE;
        end else begin
            bfs_start_q <= 1'b0;
            finished_q  <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                // Abort beats any same-cycle handshake: no position update.
                state_q      <= S_IDLE;
                move_valid_q <= 1'b0;
                busy_q       <= 1'b0;
                status_q     <= ST_NONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (run && !abort) begin
                            pos_x_q  <= start_x;
                            pos_y_q  <= start_y;
                            goal_x_q <= goal_x;
                            goal_y_q <= goal_y;
                            step_q   <= '0;
                            busy_q   <= 1'b1;
                            if ((start_x > MAX_X) || (start_y > MAX_Y) ||
                                (goal_x > MAX_X) || (goal_y > MAX_Y)) begin
                                status_q   <= ST_BLOCKED;
                                finished_q <= 1'b1;
                                state_q    <= S_FIN;
                            end else begin
                                status_q <= ST_NONE;
                                state_q  <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if ((pos_x_q == goal_x_q) && (pos_y_q == goal_y_q)) begin
                            status_q   <= ST_REACHED;
                            finished_q <= 1'b1;
                            state_q    <= S_FIN;
                        end else if (step_q == STEP_LIMIT) begin
                            status_q   <= ST_LIMIT;
                            finished_q <= 1'b1;
                            state_q    <= S_FIN;
                        end else begin
                            bfs_start_q <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Planner result is only sampled on its strobe.
                        if (bfs_done) begin
                            dist_q       <= bfs_dist;
                            plan_dir_q   <= dir_t'(bfs_dir);
                            plan_valid_q <= bfs_valid;
                            state_q      <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (!plan_valid_q || (dist_q == DIST_INF) ||
                            ((dist_q == '0) && ((pos_x_q != goal_x_q) ||
                                                (pos_y_q != goal_y_q))) ||
                            !step_in_bounds(pos_x_q, pos_y_q, plan_dir_q)) begin
                            status_q   <= ST_BLOCKED;
                            finished_q <= 1'b1;
                            state_q    <= S_FIN;
                        end else begin
                            move_dir_q   <= plan_dir_q;
                            move_valid_q <= 1'b1;
                            state_q      <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (move_ready) begin
                            case (move_dir_q)
                                DIR_N:   pos_y_q <= pos_y_q - COORD_W'(1);
                                DIR_E:   pos_x_q <= pos_x_q + COORD_W'(1);
                                DIR_S:   pos_y_q <= pos_y_q + COORD_W'(1);
                                DIR_W:   pos_x_q <= pos_x_q - COORD_W'(1);
                                default: pos_x_q <= pos_x_q;
                            endcase
                            step_q       <= step_q + DIST_W'(1);
                            move_valid_q <= 1'b0;
                            state_q      <= S_CHECK;
                        end
                    end
                    S_FIN: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        move_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bfs_start  = bfs_start_q;
    assign bfs_curr_x = pos_x_q;
    assign bfs_curr_y = pos_y_q;
    assign bfs_goal_x = goal_x_q;
    assign bfs_goal_y = goal_y_q;
    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign step_count = step_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign status     = status_q;

endmodule

// File: doc/maze_nav_controller.md
# maze_nav_controller

Closed-loop navigator directly downstream of the 10x10 BFS wavefront planner. It holds the robot's current cell and repeatedly requests a plan for that cell. It consumes the planner's distance and next-direction result and issues one move at a time to the motion/display stage over a valid/ready handshake. It advances its own position and stops on goal reached, blocked path, step limit or abort.

## Interface
- MAX_STEPS, default 99: maximum moves per run, range 1..127.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  single-cycle pulse to start navigation. Ignored while busy.
- abort  in  1  level. Returns to IDLE from any state.
- start_x, start_y  in  4 each  start cell, latched on run.
- goal_x, goal_y  in  4 each  goal cell, latched on run.
- bfs_start  out  1  one-cycle plan request to the planner.
- bfs_curr_x, bfs_curr_y  out  4 each  current position, driven to the planner.
- bfs_goal_x, bfs_goal_y  out  4 each  latched goal, driven to the planner.
- bfs_done  in  1  planner result strobe.
- bfs_dist  in  7  planner distance at the current cell. 127 means INF.
- bfs_dir  in  2  planner next direction: 00=N, 01=E, 10=S, 11=W.
- bfs_valid  in  1  bfs_dir is meaningful.
- move_valid  out  1  move offered to the downstream stage.
- move_dir  out  2  move direction, same encoding as bfs_dir.
- move_ready  in  1  downstream accepts the move.
- pos_x, pos_y  out  4 each  current position.
- step_count  out  7  moves completed in this run.
- busy  out  1  high in every state except IDLE.
- finished  out  1  one-cycle pulse when a run ends (not on abort).
- status  out  2  00=none/aborted, 01=reached, 10=blocked, 11=step limit. Held until the next run.

## Operation
- States: IDLE, CHECK, REQ, WAIT, EVAL, ISSUE, FIN.
- IDLE:
  - On run: latch start and goal into pos and goal registers, clear step_count and status, go to CHECK.
  - If start or goal coordinate > 9: go to FIN with status=10 instead.
- CHECK:
  - pos == goal: FIN, status=01.
  - Otherwise step_count == MAX_STEPS: FIN, status=11.
  - Otherwise: REQ.
- REQ: assert bfs_start for this cycle only, then go to WAIT.
- WAIT: hold until bfs_done=1, then go to EVAL. bfs_done seen in any other state is ignored.
- EVAL: uses bfs_dist, bfs_dir and bfs_valid as sampled on the bfs_done cycle (registered in WAIT).
  - bfs_valid=0, or dist=127, or dist=0 while pos != goal: FIN, status=10.
  - Direction would leave the grid (N at y=0, E at x=9, S at y=9, W at x=0): FIN, status=10.
  - Otherwise load move_dir and go to ISSUE.
- ISSUE:
  - move_valid=1; move_dir is stable until the handshake.
  - On move_valid & move_ready: update position (N: y-1, E: x+1, S: y+1, W: x-1), step_count+1, go to CHECK.
- FIN: finished=1 for one cycle, then IDLE.
- abort (any state except IDLE):
  - Next state IDLE, move_valid drops, status=00, no finished pulse.
  - Abort wins over a same-cycle handshake: position and step_count are not updated.
- bfs_curr_x/y equal pos_x/y at all times. bfs_goal_x/y equal the latched goal.

## Timing
- Reset: all outputs 0, pos=(0,0), step_count=0, status=00, state IDLE. Async assertion clears move_valid and bfs_start immediately.
- run sampled at cycle 0 → CHECK at 1 → bfs_start high at cycle 2 → WAIT from cycle 3.
- bfs_done at cycle N → EVAL at N+1 → move_valid high at N+2 (minimum).
- Handshake at cycle M → new pos_x/y and step_count visible at M+1, CHECK at M+1.
- Goal found in CHECK: FIN next cycle, finished pulse on that cycle.
- run during busy is ignored. run together with abort in IDLE: abort wins, run is ignored.

## Structure
- Shared package maze_pkg holds:
  - GRID_W=10, GRID_H=10, DIST_INF=7'h7F.
  - dir_t enum {DIR_N, DIR_E, DIR_S, DIR_W}.
  - nav_status_t enum {ST_NONE, ST_REACHED, ST_BLOCKED, ST_LIMIT}.
  - Pure function step_in_bounds(x, y, dir).
- No sub-module. Single FSM plus position and step counters.

## Test plan
- start=goal=(3,3), run → no bfs_start, finished 2 cycles after run, status=01, step_count=0.
- Corridor (0,0)→(3,0); planner model returns E with dist 3,2,1; move_ready tied 1 → three moves E, pos=(3,0), step_count=3, status=01.
- Planner returns bfs_valid=0 (and separately dist=127) → status=10, move_valid never asserted, pos unchanged.
- move_ready held low 5 cycles in ISSUE → move_valid=1 and move_dir constant throughout, pos unchanged; update lands the cycle after ready rises.
- MAX_STEPS=2, goal 5 cells away → after exactly 2 moves status=11, finished pulses.
- Abort asserted in WAIT and on a handshake cycle → IDLE, status=00, no pos update, no finished. Async rst mid-ISSUE → move_valid=0 before the next clock edge.
